// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned shift-add multiplier built around one shared
// 4-bit adder; one add-and-shift iteration per CALC cycle, 8-bit result.
module shift_add_mult (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] a;
    logic [3:0] acc;
    logic [3:0] q;
    logic [2:0] cnt;

    logic [4:0] sum;
    logic       c;
    logic [3:0] acc_nxt;
    logic [3:0] q_nxt;
    logic       last;

    // The add carry lands in ACC[3] after the shift, so nothing is lost.
    always_comb begin
        sum     = q[0] ? ({1'b0, acc} + {1'b0, a}) : {1'b0, acc};
        c       = sum[4];
        acc_nxt = {c, sum[3:1]};
        q_nxt   = {sum[0], q[3:1]};
        last    = (cnt == 3'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? CALC : IDLE;
            CALC:    state_nxt = last ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= 4'd0;
            acc     <= 4'd0;
            q       <= 4'd0;
            cnt     <= 3'd0;
            product <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a   <= multiplicand;
                        q   <= multiplier;
                        acc <= 4'd0;
                        cnt <= 3'd0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 3'd1;
                    if (last) begin
                        product <= {acc_nxt, q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult: reset, corner operands,
// ignored starts, mid-run reset, back-to-back starts and a full sweep.
module tb_shift_add_mult;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic [7:0] product;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_prod = 8'd0;

    shift_add_mult dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: start sampled at edge N, busy after N..N+3,
    // done after N+4, idle after N+5. Operands are scrambled after sampling.
    task automatic run_mult(input logic [3:0] x, input logic [3:0] y,
                            input logic [7:0] exp, input string tag);
        start        = 1'b1;
        multiplicand = x;
        multiplier   = y;
        tick();
        start        = 1'b0;
        multiplicand = ~x;
        multiplier   = ~y;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, "_nodone"}, {7'd0, done}, 8'd0);
            chk({tag, "_hold"}, product, exp_prod);
            tick();
        end
        chk({tag, "_done"}, {7'd0, done}, 8'd1);
        chk({tag, "_busy_lo"}, {7'd0, busy}, 8'd0);
        chk({tag, "_prod"}, product, exp);
        exp_prod = exp;
        tick();
        chk({tag, "_done_lo"}, {7'd0, done}, 8'd0);
        chk({tag, "_idle"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        int last_done;
        int pulses;

        rst          = 1'b1;
        start        = 1'b1;
        multiplicand = 4'hF;
        multiplier   = 4'hF;
        tick();
        tick();
        chk("rst_prod", product, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", {7'd0, busy}, 8'd0);

        run_mult(4'd15, 4'd15, 8'hE1, "m15x15");
        run_mult(4'd12, 4'd11, 8'h84, "m12x11");
        run_mult(4'd0, 4'd9, 8'h00, "m0x9");
        run_mult(4'd1, 4'd13, 8'h0D, "m1x13");

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_hold", product, 8'h0D);
            chk("idle_nobusy", {7'd0, busy}, 8'd0);
        end

        // Start pulse during CALC must be ignored.
        start        = 1'b1;
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        tick();
        multiplicand = 4'd7;
        multiplier   = 4'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ign_done", {7'd0, done}, 8'd1);
        chk("ign_prod", product, 8'h0F);
        exp_prod = 8'h0F;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("ign_nodone", {7'd0, done}, 8'd0);
            chk("ign_nobusy", {7'd0, busy}, 8'd0);
        end
        chk("ign_keep", product, 8'h0F);

        // Reset on the 2nd CALC cycle aborts the run.
        start        = 1'b1;
        multiplicand = 4'd9;
        multiplier   = 4'd6;
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy_pre", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        chk("abort_prod", product, 8'h00);
        exp_prod = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_nodone", {7'd0, done}, 8'd0);
        end
        run_mult(4'd9, 4'd6, 8'h36, "m9x6");

        // start held high: one result every 6 cycles.
        start        = 1'b1;
        multiplicand = 4'd2;
        multiplier   = 4'd3;
        last_done    = -1;
        pulses       = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            if (done) begin
                pulses++;
                chk("b2b_prod", product, 8'h06);
                if (last_done >= 0)
                    chk("b2b_period", 8'(cyc - last_done), 8'd6);
                last_done = cyc;
            end
            chk("b2b_excl", {7'd0, busy & done}, 8'd0);
        end
        start = 1'b0;
        chk("b2b_pulses", 8'(pulses), 8'd4);
        for (int i = 0; i < 6; i++) tick();
        exp_prod = 8'h06;

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_mult(4'(x), 4'(y), 8'(x * y), "sweep");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits, matching the team's 4-bit adder datapath.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 multiplicand  input  4  unsigned operand A; sampled with start.
REQ-006 multiplier  input  4  unsigned operand B; sampled with start.
REQ-007 product  output  8  unsigned A*B; registered.
REQ-008 busy  output  1  high while iterations are in progress (CALC state).
REQ-009 done  output  1  single-cycle pulse; product valid.

Function
REQ-010 The block SHALL sequence a shared 4-bit + 4-bit -> 5-bit add (sum[3:0] plus carry-out) as a shift-add multiplier. There SHALL be one add per iteration.
REQ-011 Internal registers:
- A[3:0]: latched multiplicand.
- ACC[3:0]: accumulator.
- Q[3:0]: multiplier/low product.
- C: carry.
- CNT[2:0]: iteration count.
REQ-012 FSM states SHALL be IDLE, CALC and DONE; encoding is free.
REQ-013 IDLE with start=1 at an edge:
- A <= multiplicand.
- Q <= multiplier.
- ACC <= 0.
- CNT <= 0.
- Next state CALC.
REQ-014 IDLE with start=0: all registers hold; product holds its last value.
REQ-015 Each CALC edge:
- {C,ACC} = Q[0] ? ACC+A (5-bit) : {0,ACC}.
- Then {ACC,Q} <= {C,ACC,Q} >> 1.
- CNT <= CNT+1.
REQ-016 CALC -> DONE SHALL occur on the edge performing the 4th iteration (CNT==3); exactly 4 CALC cycles SHALL occur.
REQ-017 Entering DONE, product SHALL be loaded with {ACC,Q} from the 4th iteration; the add carry SHALL never be lost (8-bit result is exact for all 256 operand pairs).
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: start sampled at edge N -> busy=1 after edges N..N+3 -> done=1 and product valid after edge N+4 -> IDLE after edge N+5.
REQ-020 busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE; the two SHALL never be high together.
REQ-021 start in CALC or DONE SHALL be ignored (no queueing); operand input changes after sampling SHALL not affect the result.
REQ-022 product SHALL hold its value from DONE until the next DONE or rst; it SHALL not show partial results during CALC.
REQ-023 Back-to-back: start held high SHALL begin a new operation on the first IDLE cycle, giving a period of 6 cycles per result.

Reset
REQ-024 rst=1 at an edge SHALL, from any state, force the following; rst SHALL take priority over start:
- State IDLE.
- product=0, busy=0, done=0.
- A, ACC, Q, C, CNT = 0.
REQ-025 rst asserted mid-CALC SHALL abort the operation: no done pulse, product=0; the next start after rst deasserts SHALL run normally.

Verification
REQ-026 A=15, B=15, start one cycle -> busy high 4 cycles, done pulse after 5th edge, product=0xE1 (225).
REQ-027 A=12, B=11 -> product=0x84 (132); A=0, B=9 -> product=0x00 with done still pulsed; A=1, B=13 -> product=0x0D.
REQ-028 Start A=3, B=5; during CALC pulse start with A=7, B=7 -> first result 0x0F, second request ignored, no second done.
REQ-029 Start A=9, B=6; assert rst on 2nd CALC cycle -> next cycle busy=0, done=0, product=0; then A=9, B=6 -> 0x36 (54).
REQ-030 start held high continuously with A=2, B=3 -> done pulses every 6 cycles, product=0x06 each time.
REQ-031 Exhaustive sweep of all 256 (A,B) pairs -> product == A*B for every pair, latency exactly 5 edges from start to done.
